// File: rtl/mat_pkg.sv
// Shared constants and state type for the row multiply-accumulate datapath.
//   N_ROWS / N_COLS : matrix geometry (rows per calculation, terms per row)
//   DATA_W / FRAC_W : signed operand width and fixed-point fraction bits
//   ACC_W           : accumulator width, wide enough for N_COLS <= 16 full products
//   ROW_W / COL_W   : row-index and column-index widths
//   CADDR_W         : coefficient ROM address width
package mat_pkg;

  localparam int N_ROWS  = 10;
  localparam int N_COLS  = 10;
  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 8;
  localparam int ACC_W   = 2 * DATA_W + 4;
  localparam int ROW_W   = 4;
  localparam int COL_W   = 4;
  localparam int CADDR_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    WRITE
  } mac_state_t;

endpackage

// File: rtl/row_mac_engine_mac_unit.sv
// mac_unit: signed multiply-accumulate with clear, plus scaled/saturated output.
//   clk, reset : clock and synchronous active-high reset (clears accumulator)
//   clear      : zero the accumulator (takes priority over acc_en)
//   acc_en     : add a*b to the accumulator this cycle
//   a, b       : signed DATA_W operands
//   sat_out    : (acc >>> FRAC_W) clamped to the signed DATA_W range
module mac_unit
  import mat_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     acc_en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] sat_out
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    shifted;

  assign prod = a * b;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

  always_comb begin
    shifted = acc >>> FRAC_W;
    if (shifted > SAT_MAX) begin
      sat_out = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      sat_out = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat_out = shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/row_mac_engine.sv
// row_mac_engine: computes one matrix row dot-product per begin_mult request.
//   clk, reset   : clock, synchronous active-high reset (aborts a row in flight)
//   begin_mult   : level request from controller, sampled only in IDLE
//   res_add      : row index / result address, latched at row start
//   coef_rd_en   : read strobe for coefficient ROM and vector regfile
//   coef_addr    : row*N_COLS + col
//   coef_data    : signed coefficient, valid one cycle after coef_rd_en
//   vec_addr     : column index
//   vec_data     : signed vector element, valid one cycle after coef_rd_en
//   res_wr_en    : one-cycle result write strobe
//   res_wr_addr  : latched row index (during the write)
//   res_wr_data  : saturated scaled sum (during the write)
//   done_row     : one-cycle completion pulse
//   busy         : high whenever not IDLE
//   row_err      : pulses with done_row when the row index is out of range
module row_mac_engine
  import mat_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     begin_mult,
  input  logic [ROW_W-1:0]         res_add,
  output logic                     coef_rd_en,
  output logic [CADDR_W-1:0]       coef_addr,
  input  logic signed [DATA_W-1:0] coef_data,
  output logic [COL_W-1:0]         vec_addr,
  input  logic signed [DATA_W-1:0] vec_data,
  output logic                     res_wr_en,
  output logic [ROW_W-1:0]         res_wr_addr,
  output logic signed [DATA_W-1:0] res_wr_data,
  output logic                     done_row,
  output logic                     busy,
  output logic                     row_err
);

  mac_state_t              state;
  mac_state_t              state_next;
  logic [ROW_W-1:0]        row_q;
  logic [COL_W-1:0]        col_q;
  logic                    rd_valid_q;
  logic                    start;
  logic                    row_ok;
  logic                    last_col;
  logic signed [DATA_W-1:0] mac_out;

  assign row_ok   = (row_q < ROW_W'(N_ROWS));
  assign last_col = (col_q == COL_W'(N_COLS - 1));
  assign busy     = (state != IDLE);

  always_comb begin
    state_next = state;
    start      = 1'b0;
    coef_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (begin_mult) begin
          start      = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        // Out-of-range rows still walk the columns so done_row keeps its latency.
        coef_rd_en = row_ok;
        if (last_col) begin
          state_next = DRAIN;
        end
      end
      DRAIN:   state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign coef_addr = coef_rd_en ? (CADDR_W'(row_q) * CADDR_W'(N_COLS) + CADDR_W'(col_q)) : '0;
  assign vec_addr  = coef_rd_en ? col_q : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      rd_valid_q <= 1'b0;
      res_wr_en  <= 1'b0;
      done_row   <= 1'b0;
      row_err    <= 1'b0;
    end else begin
      state      <= state_next;
      rd_valid_q <= coef_rd_en;
      if (start) begin
        row_q <= res_add;
        col_q <= '0;
      end else if (state == FETCH) begin
        col_q <= col_q + 1'b1;
      end
      // Registered from DRAIN so these pulses coincide with the WRITE state.
      done_row  <= (state == DRAIN);
      res_wr_en <= (state == DRAIN) && row_ok;
      row_err   <= (state == DRAIN) && !row_ok;
    end
  end

  // The last product lands in the accumulator on the DRAIN->WRITE edge,
  // so the saturated result is read straight from it during WRITE.
  assign res_wr_addr = res_wr_en ? row_q : '0;
  assign res_wr_data = res_wr_en ? mac_out : '0;

  mac_unit u_mac (
    .clk    (clk),
    .reset  (reset),
    .clear  (start),
    .acc_en (rd_valid_q),
    .a      (coef_data),
    .b      (vec_data),
    .sat_out(mac_out)
  );

endmodule
